vga_draw_arbiter: RTL

Shares the single VGA adapter pixel-write port between three independent pixel-stream renderers: keyboard renderer, waveform renderer and screen-clear engine. Each renderer requests the port, draws a complete frame segment and signals completion. The arbiter grants one requester at a time in round-robin order and muxes that requester's coordinates, colour and plot strobe onto the adapter port. A watchdog revokes any grant held too long.

---
 rtl/vga_draw_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter sharing one VGA adapter pixel-write port between three renderers.
// A watchdog revokes any grant held longer than TIMEOUT cycles.
module vga_draw_arbiter #(
  parameter int TIMEOUT   = 20480,
  parameter int TIMEOUT_W = 15
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [2:0]  iReq,
  input  logic [2:0]  iDone,
  input  logic [2:0]  iPlot,
  input  logic [23:0] iX,
  input  logic [20:0] iY,
  input  logic [8:0]  iColour,
  output logic [2:0]  oGrant,
  output logic [7:0]  oX,
  output logic [6:0]  oY,
  output logic [2:0]  oColour,
  output logic        oPlot,
  output logic        oBusy,
  output logic        oTimeout,
  output logic [1:0]  oState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             grant_q, grant_d;
  logic [1:0]             last_q, last_d;
  logic [TIMEOUT_W-1:0]   wd_q, wd_d;
  logic                   timeout_q, timeout_d;

  logic [1:0] c0, c1, c2, win, gid;
  logic       req_g, done_g, wd_last;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] id);
    case (id)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Search order starts just after the previous winner so it drops to lowest priority.
  assign c0  = inc3(last_q);
  assign c1  = inc3(c0);
  assign c2  = inc3(c1);
  assign win = iReq[c0] ? c0 : (iReq[c1] ? c1 : c2);

  assign gid     = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);
  assign req_g   = |(iReq & grant_q);
  assign done_g  = |(iDone & grant_q);
  assign wd_last = (wd_q == TIMEOUT_W'(TIMEOUT - 1));

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      last_q    <= 2'd2;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|iReq) begin
          grant_d = onehot(win);
          wd_d    = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        wd_d = wd_q + TIMEOUT_W'(1);
        // A done/abort on the last allowed cycle is a normal exit, not a timeout.
        if (done_g || !req_g || wd_last) begin
          state_d   = RELEASE;
          grant_d   = 3'b000;
          last_d    = gid;
          timeout_d = wd_last && done_g == 1'b0 && req_g;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  always_comb begin
    oX      = 8'd0;
    oY      = 7'd0;
    oColour = 3'd0;
    oPlot   = 1'b0;
    if (state_q == GRANT) begin
      case (grant_q)
        3'b001: begin
          oX = iX[7:0];   oY = iY[6:0];   oColour = iColour[2:0]; oPlot = iPlot[0];
        end
        3'b010: begin
          oX = iX[15:8];  oY = iY[13:7];  oColour = iColour[5:3]; oPlot = iPlot[1];
        end
        3'b100: begin
          oX = iX[23:16]; oY = iY[20:14]; oColour = iColour[8:6]; oPlot = iPlot[2];
        end
        default: begin
          oPlot = 1'b0;
        end
      endcase
    end
  end

  assign oGrant   = grant_q;
  assign oBusy    = (state_q != IDLE);
  assign oTimeout = timeout_q;
  assign oState   = state_q;

endmodule
